music_seq_ctrl: RTL and testbench

Note sequencer for the music player. It steps through the note ROM of the song selected by `music_reg` and runs the play/pause state machine. It times each note in beats and feeds note codes to the tone generator. It restarts the current song from note 0 whenever the song selection changes.

---
 rtl/music_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_music_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_seq_ctrl.sv
// Purpose: note sequencer for the music player; walks the selected song's ROM and runs play/pause.
// Latency: play_key -> first note on tone generator in 3 cycles; 2-cycle gap (FETCH, LOAD) between notes.
// Backpressure: none; the ROM answers in a fixed 1 cycle and play_key is a one-cycle pulse, never held off.
module music_seq_ctrl #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       music_reg,
  input  logic             play_key,
  output logic [IDX_W+1:0] rom_addr,
  input  logic [4:0]       rom_note,
  input  logic [1:0]       rom_dur,
  output logic [4:0]       note_code,
  output logic             note_en,
  output logic             note_load,
  output logic             playing,
  output logic             song_done
);

  // Beat counter must hold 0..BEAT_CYCLES-1; keep at least one bit.
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [4:0]    END_MARK  = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       song_q;
  logic [IDX_W-1:0] idx;
  logic [BW-1:0]    bcnt;
  logic [1:0]       beats;
  logic             refetch;

  logic             chg;
  logic             tick;
  logic             note_over;
  logic             is_end;
  logic             idx_last;

  assign chg       = (music_reg != song_q);
  assign tick      = (bcnt == BCNT_LAST);
  assign note_over = tick && (beats == 2'd0);
  assign is_end    = (rom_note == END_MARK);
  assign idx_last  = &idx;

  // The ROM always sees the latched song and the current note index.
  assign rom_addr = {song_q, idx};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a song change outranks play_key and beat ticks outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (play_key) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = chg ? S_FETCH : S_LOAD;
      end
      S_LOAD: begin
        if (chg)                     state_nxt = S_FETCH;
        else if (is_end && idx == '0) state_nxt = S_IDLE;
        else if (is_end)             state_nxt = S_FETCH;
        else                         state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (chg)            state_nxt = S_FETCH;
        else if (play_key)  state_nxt = S_PAUSE;
        else if (note_over) state_nxt = S_FETCH;
      end
      S_PAUSE: begin
        if (chg)           state_nxt = S_PAUSE;
        else if (play_key) state_nxt = refetch ? S_FETCH : S_PLAY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    note_en = (state == S_PLAY);
    playing = (state == S_FETCH) || (state == S_LOAD) || (state == S_PLAY);
  end

  // Song select is sampled every cycle so a change is seen exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q <= 2'b00;
    end else begin
      song_q <= music_reg;
    end
  end

  // Note datapath: index, beat timing, note latch, refetch flag and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      bcnt      <= '0;
      beats     <= 2'd0;
      refetch   <= 1'b0;
      note_code <= 5'd0;
      note_load <= 1'b0;
      song_done <= 1'b0;
    end else begin
      note_load <= 1'b0;
      song_done <= 1'b0;
      case (state)
        S_IDLE: begin
          idx <= '0;
        end
        S_FETCH: begin
          if (chg) begin
            idx   <= '0;
            bcnt  <= '0;
            beats <= 2'd0;
          end
        end
        S_LOAD: begin
          if (chg) begin
            idx   <= '0;
            bcnt  <= '0;
            beats <= 2'd0;
          end else if (is_end) begin
            // Marker at index 0 means an empty song; otherwise loop the song.
            song_done <= 1'b1;
            idx       <= '0;
          end else begin
            note_code <= rom_note;
            beats     <= rom_dur;
            bcnt      <= '0;
            note_load <= 1'b1;
          end
        end
        S_PLAY: begin
          if (chg) begin
            idx   <= '0;
            bcnt  <= '0;
            beats <= 2'd0;
          end else if (tick) begin
            bcnt <= '0;
            if (beats != 2'd0) begin
              beats <= beats - 2'd1;
            end else begin
              idx <= idx + 1'b1;
              if (idx_last) song_done <= 1'b1;
              // Pausing on the note's final cycle: the note is finished, so
              // resuming must go straight to the next fetch.
              if (play_key) refetch <= 1'b1;
            end
          end else begin
            // The cycle that sees play_key still plays, so it still counts.
            bcnt <= bcnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (chg) begin
            idx     <= '0;
            refetch <= 1'b1;
          end else if (play_key && refetch) begin
            refetch <= 1'b0;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with BEAT_CYCLES=4, IDX_W=2 and a 16-entry registered ROM model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Expected values below are hand-derived cycle by cycle from the sequencer's behaviour.
module tb_music_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] music_reg;
  logic       play_key;
  logic [3:0] rom_addr;
  logic [4:0] rom_note;
  logic [1:0] rom_dur;
  logic [4:0] note_code;
  logic       note_en;
  logic       note_load;
  logic       playing;
  logic       song_done;

  int tests;
  int fails;

  logic [4:0] rn [16];
  logic [1:0] rd [16];

  music_seq_ctrl #(.BEAT_CYCLES(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .music_reg (music_reg),
    .play_key  (play_key),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .rom_dur   (rom_dur),
    .note_code (note_code),
    .note_en   (note_en),
    .note_load (note_load),
    .playing   (playing),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    rom_note <= rn[rom_addr];
    rom_dur  <= rd[rom_addr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // song 0: 3/dur1, 7/dur0, end
    rn[0]  = 5'd3;  rd[0]  = 2'd1;
    rn[1]  = 5'd7;  rd[1]  = 2'd0;
    rn[2]  = 5'h1F; rd[2]  = 2'd0;
    rn[3]  = 5'h1F; rd[3]  = 2'd0;
    // song 1: empty
    rn[4]  = 5'h1F; rd[4]  = 2'd0;
    rn[5]  = 5'h1F; rd[5]  = 2'd0;
    rn[6]  = 5'h1F; rd[6]  = 2'd0;
    rn[7]  = 5'h1F; rd[7]  = 2'd0;
    // song 2: 5/dur0, 9/dur2, end
    rn[8]  = 5'd5;  rd[8]  = 2'd0;
    rn[9]  = 5'd9;  rd[9]  = 2'd2;
    rn[10] = 5'h1F; rd[10] = 2'd0;
    rn[11] = 5'h1F; rd[11] = 2'd0;
    // song 3: four notes, no marker (wraps)
    rn[12] = 5'd1;  rd[12] = 2'd0;
    rn[13] = 5'd2;  rd[13] = 2'd0;
    rn[14] = 5'd4;  rd[14] = 2'd0;
    rn[15] = 5'd6;  rd[15] = 2'd0;
    rom_note  = 5'd0;
    rom_dur   = 2'd0;

    rst_n     = 1'b0;
    music_reg = 2'd0;
    play_key  = 1'b0;
    step(2);
    chk("rst_note_code", 32'(note_code), 0);
    chk("rst_note_en",   32'(note_en),   0);
    chk("rst_note_load", 32'(note_load), 0);
    chk("rst_playing",   32'(playing),   0);
    chk("rst_song_done", 32'(song_done), 0);
    chk("rst_rom_addr",  32'(rom_addr),  0);
    rst_n = 1'b1;
    step(2);

    // ---- basic play of song 0 ----
    play_key = 1'b1;
    step(1);                                   // t+1 FETCH
    play_key = 1'b0;
    chk("bp_fetch_playing", 32'(playing), 1);
    chk("bp_fetch_en",      32'(note_en), 0);
    chk("bp_fetch_addr",    32'(rom_addr), 0);
    step(1);                                   // t+2 LOAD
    chk("bp_load_en",   32'(note_en),   0);
    chk("bp_load_pls",  32'(note_load), 0);
    step(1);                                   // t+3 first PLAY
    chk("bp_n0_load", 32'(note_load), 1);
    chk("bp_n0_en",   32'(note_en),   1);
    chk("bp_n0_code", 32'(note_code), 3);
    for (int i = 1; i < 8; i++) begin
      step(1);
      chk("bp_n0_en_hold",   32'(note_en),   1);
      chk("bp_n0_code_hold", 32'(note_code), 3);
      chk("bp_n0_load_low",  32'(note_load), 0);
    end
    step(1);                                   // t+11 FETCH idx1
    chk("bp_gap1_en",   32'(note_en),  0);
    chk("bp_gap1_addr", 32'(rom_addr), 1);
    step(1);                                   // t+12 LOAD
    chk("bp_gap2_en", 32'(note_en), 0);
    step(1);                                   // t+13 PLAY note 7
    chk("bp_n1_load", 32'(note_load), 1);
    chk("bp_n1_code", 32'(note_code), 7);
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk("bp_n1_en_hold", 32'(note_en), 1);
    end
    step(1);                                   // t+17 FETCH idx2
    chk("bp_n1_end_en", 32'(note_en),  0);
    chk("bp_end_addr",  32'(rom_addr), 2);
    step(2);                                   // t+19 after marker LOAD
    chk("bp_done",       32'(song_done), 1);
    chk("bp_loop_addr",  32'(rom_addr),  0);
    chk("bp_loop_play",  32'(playing),   1);
    step(1);
    chk("bp_done_pulse", 32'(song_done), 0);
    step(1);                                   // t+21 looped note 3
    chk("bp_loop_load", 32'(note_load), 1);
    chk("bp_loop_code", 32'(note_code), 3);

    // ---- pause / resume on the 4-cycle note 7 ----
    step(10);                                  // P: note 7 first cycle
    chk("pa_n1_load", 32'(note_load), 1);
    chk("pa_n1_code", 32'(note_code), 7);
    step(2);                                   // P+2, third PLAY cycle
    play_key = 1'b1;
    step(1);                                   // P+3 PAUSE
    play_key = 1'b0;
    chk("pa_en_drop",  32'(note_en), 0);
    chk("pa_not_play", 32'(playing), 0);
    step(19);                                  // P+22
    chk("pa_still_paused", 32'(note_en),  0);
    chk("pa_idx_frozen",   32'(rom_addr), 1);
    play_key = 1'b1;
    step(1);                                   // P+23 resumed, last cycle
    play_key = 1'b0;
    chk("pa_resume_en",   32'(note_en),   1);
    chk("pa_resume_code", 32'(note_code), 7);
    step(1);                                   // P+24 FETCH
    chk("pa_one_left_en", 32'(note_en),  0);
    chk("pa_next_addr",   32'(rom_addr), 2);
    step(2);
    chk("pa_done", 32'(song_done), 1);

    // ---- song change mid-note ----
    step(2);                                   // note 3 first PLAY cycle
    chk("sc_n0_load", 32'(note_load), 1);
    step(1);                                   // c: mid-note
    music_reg = 2'd2;
    step(1);                                   // c+1 FETCH
    chk("sc_en_low",   32'(note_en),  0);
    chk("sc_playing",  32'(playing),  1);
    chk("sc_new_addr", 32'(rom_addr), 8);
    step(2);                                   // c+3
    chk("sc_new_load", 32'(note_load), 1);
    chk("sc_new_code", 32'(note_code), 5);

    // ---- song change while paused ----
    step(6);                                   // c+9 note 9
    chk("sp_n9_code", 32'(note_code), 9);
    play_key = 1'b1;
    step(1);                                   // c+10 PAUSE
    chk("sp_paused_en",   32'(note_en),  0);
    chk("sp_paused_addr", 32'(rom_addr), 9);
    music_reg = 2'd0;                          // chg with play_key held
    step(1);                                   // c+11
    play_key = 1'b0;
    chk("sp_key_dropped_en", 32'(note_en),  0);
    chk("sp_stay_pause",     32'(playing),  0);
    chk("sp_idx_reset",      32'(rom_addr), 0);
    step(1);                                   // c+12
    chk("sp_still_pause", 32'(playing), 0);
    play_key = 1'b1;
    step(1);                                   // c+13 FETCH
    play_key = 1'b0;
    chk("sp_refetch_play", 32'(playing),  1);
    chk("sp_refetch_en",   32'(note_en),  0);
    chk("sp_refetch_addr", 32'(rom_addr), 0);
    step(2);                                   // c+15
    chk("sp_new_load", 32'(note_load), 1);
    chk("sp_new_code", 32'(note_code), 3);

    // ---- empty song ----
    music_reg = 2'd1;
    step(1);
    chk("es_chg_addr", 32'(rom_addr), 4);
    step(2);
    chk("es_chg_done", 32'(song_done), 1);
    chk("es_chg_idle", 32'(playing),   0);
    step(1);
    chk("es_done_pulse", 32'(song_done), 0);
    play_key = 1'b1;                           // u, from IDLE
    step(1);
    play_key = 1'b0;
    chk("es_fetch_play", 32'(playing),  1);
    chk("es_fetch_addr", 32'(rom_addr), 4);
    step(2);                                   // u+3
    chk("es_done",    32'(song_done), 1);
    chk("es_idle",    32'(playing),   0);
    chk("es_idle_en", 32'(note_en),   0);
    step(1);
    chk("es_done_low", 32'(song_done), 0);
    chk("es_stay_idle", 32'(playing),  0);

    // ---- change + key together in IDLE, then index wrap on song 3 ----
    music_reg = 2'd3;
    play_key  = 1'b1;
    step(1);                                   // w+1
    play_key = 1'b0;
    chk("ic_fetch_play", 32'(playing),  1);
    chk("ic_fetch_addr", 32'(rom_addr), 12);
    step(2);                                   // w+3
    chk("wr_n0_load", 32'(note_load), 1);
    chk("wr_n0_code", 32'(note_code), 1);
    step(21);                                  // w+24 last cycle of idx 3
    chk("wr_n3_en",   32'(note_en),   1);
    chk("wr_n3_code", 32'(note_code), 6);
    chk("wr_n3_addr", 32'(rom_addr),  15);
    step(1);                                   // w+25
    chk("wr_done",    32'(song_done), 1);
    chk("wr_addr",    32'(rom_addr),  12);
    chk("wr_en_low",  32'(note_en),   0);
    step(1);
    chk("wr_done_low", 32'(song_done), 0);
    step(1);                                   // w+27
    chk("wr_again_load", 32'(note_load), 1);
    chk("wr_again_code", 32'(note_code), 1);

    // ---- asynchronous reset mid-note ----
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_note_code", 32'(note_code), 0);
    chk("ar_note_en",   32'(note_en),   0);
    chk("ar_note_load", 32'(note_load), 0);
    chk("ar_playing",   32'(playing),   0);
    chk("ar_song_done", 32'(song_done), 0);
    chk("ar_rom_addr",  32'(rom_addr),  0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("ar_rel_done",  32'(song_done), 0);
    chk("ar_rel_load",  32'(note_load), 0);
    chk("ar_rel_play",  32'(playing),   0);
    chk("ar_rel_addr",  32'(rom_addr),  12);
    step(1);
    chk("ar_rel_done2", 32'(song_done), 0);
    chk("ar_rel_idle",  32'(playing),   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
